// File: rtl/stream_window_3.sv
// Streaming 3x3 neighbourhood generator: two line buffers plus a 3x3 shift register,
// emitting a registered window for every accepted pixel whose neighbourhood is fully in-frame.
module stream_window_3 #(
  parameter int unsigned PRECISION = 16,
  parameter int unsigned WIDTH     = 640,
  parameter int unsigned HEIGHT    = 480
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic signed [PRECISION-1:0]            pixel_in,
  input  logic                                   pixel_valid,
  input  logic                                   sof,
  output logic signed [2:0][2:0][PRECISION-1:0]  window,
  output logic                                   window_valid,
  output logic [$clog2(HEIGHT)-1:0]              center_row,
  output logic [$clog2(WIDTH)-1:0]               center_col,
  output logic                                   frame_end
);

  localparam int unsigned ColW = $clog2(WIDTH);
  localparam int unsigned RowW = $clog2(HEIGHT);
  localparam logic [ColW-1:0] LastCol = ColW'(WIDTH - 1);
  localparam logic [RowW-1:0] LastRow = RowW'(HEIGHT - 1);

  logic [ColW-1:0] col_q, col_d, cur_col;
  logic [RowW-1:0] row_q, row_d, cur_row;
  logic signed [2:0][2:0][PRECISION-1:0] win_q, win_d;
  logic valid_q, valid_d;
  logic fe_q, fe_d;
  logic [RowW-1:0] cr_q, cr_d;
  logic [ColW-1:0] cc_q, cc_d;
  logic [PRECISION-1:0] top, mid;

  // lb0 holds the previous row, lb1 the row before that
  logic [PRECISION-1:0] lb0_q [WIDTH];
  logic [PRECISION-1:0] lb1_q [WIDTH];

  always_comb begin
    // sof forces the current pixel to (0,0) regardless of the counters
    cur_row = sof ? '0 : row_q;
    cur_col = sof ? '0 : col_q;
    top     = lb1_q[cur_col];
    mid     = lb0_q[cur_col];
    col_d   = col_q;
    row_d   = row_q;
    win_d   = win_q;
    valid_d = 1'b0;
    fe_d    = 1'b0;
    cr_d    = cr_q;
    cc_d    = cc_q;
    if (pixel_valid) begin
      for (int i = 0; i < 3; i++) begin
        win_d[i][0] = win_q[i][1];
        win_d[i][1] = win_q[i][2];
      end
      win_d[0][2] = top;
      win_d[1][2] = mid;
      win_d[2][2] = pixel_in;
      valid_d = (cur_row >= RowW'(2)) && (cur_col >= ColW'(2));
      if (valid_d) begin
        cr_d = cur_row - RowW'(1);
        cc_d = cur_col - ColW'(1);
      end
      fe_d = (cur_row == LastRow) && (cur_col == LastCol);
      if (cur_col == LastCol) begin
        col_d = '0;
        row_d = (cur_row == LastRow) ? '0 : cur_row + RowW'(1);
      end else begin
        col_d = cur_col + ColW'(1);
        row_d = cur_row;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      col_q   <= '0;
      row_q   <= '0;
      win_q   <= '0;
      valid_q <= 1'b0;
      fe_q    <= 1'b0;
      cr_q    <= '0;
      cc_q    <= '0;
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      win_q   <= win_d;
      valid_q <= valid_d;
      fe_q    <= fe_d;
      cr_q    <= cr_d;
      cc_q    <= cc_d;
    end
  end

  // No reset on the line buffers so they can map onto RAM
  always_ff @(posedge clk) begin
    if (pixel_valid && !reset) begin
      lb1_q[cur_col] <= lb0_q[cur_col];
      lb0_q[cur_col] <= pixel_in;
    end
  end

  assign window       = win_q;
  assign window_valid = valid_q;
  assign center_row   = cr_q;
  assign center_col   = cc_q;
  assign frame_end    = fe_q;

endmodule
